// File: rtl/uart_rx.sv
// Serial-to-parallel UART receiver: mid-bit sampling from a cycle counter,
// held output word with valid/ready handshake and parity/framing/overrun flags.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLK_RATE   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int WORD_WIDTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  rx_data_in,
    output logic [WORD_WIDTH-1:0] rx_data_out,
    output logic                  rx_data_valid,
    input  logic                  rx_data_ready,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err,
    output logic                  rx_overrun,
    output logic                  rx_busy
);

    localparam int CLKS_PER_BIT = CLK_RATE / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(WORD_WIDTH + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_WIDTH - 1);
    localparam logic             ODD_MODE  = (PARITY_ODD != 0);
    localparam logic             HAS_PAR   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } state_t;

    // Mismatch between received data+parity and the configured parity sense.
    function automatic logic parity_err_f(input logic [WORD_WIDTH-1:0] data,
                                          input logic                  par_bit);
        return (^data) ^ par_bit ^ ODD_MODE;
    endfunction

    state_t                  state_r;
    logic                    sync1_r;
    logic                    sync_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic [WORD_WIDTH-1:0]   shift_r;
    logic                    frame_perr_r;
    logic                    frame_ferr_r;
    logic                    frame_done_r;

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clock) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync_r  <= 1'b1;
        end else begin
            sync1_r <= rx_data_in;
            sync_r  <= sync1_r;
        end
    end

    // Frame FSM: bit timing, shifting, per-frame error capture and busy flag.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            shift_r      <= {WORD_WIDTH{1'b0}};
            frame_perr_r <= 1'b0;
            frame_ferr_r <= 1'b0;
            frame_done_r <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!sync_r) begin
                        state_r      <= ST_START;
                        cnt_r        <= {CNT_W{1'b0}};
                        frame_perr_r <= 1'b0;
                        rx_busy      <= 1'b1;
                    end else begin
                        rx_busy <= 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt_r == HALF_LAST) begin
                        if (sync_r) begin
                            state_r <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state_r <= ST_DATA;
                            cnt_r   <= {CNT_W{1'b0}};
                            idx_r   <= {IDX_W{1'b0}};
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        shift_r <= {sync_r, shift_r[WORD_WIDTH-1:1]};
                        idx_r   <= idx_r + IDX_W'(1);
                        if (idx_r == IDX_LAST) begin
                            state_r <= HAS_PAR ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r        <= {CNT_W{1'b0}};
                        frame_perr_r <= parity_err_f(shift_r, sync_r);
                        state_r      <= ST_STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r        <= {CNT_W{1'b0}};
                        frame_done_r <= 1'b1;
                        frame_ferr_r <= ~sync_r;
                        // Leaving at mid-stop gives half a bit to catch the next start edge.
                        if (sync_r) begin
                            state_r <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state_r <= ST_BREAK_WAIT;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_BREAK_WAIT: begin
                    if (sync_r) begin
                        state_r <= ST_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    // Output holding register: delivery, overrun detection and handshake.
    always_ff @(posedge clock) begin
        if (rst) begin
            rx_data_out   <= {WORD_WIDTH{1'b0}};
            rx_data_valid <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (frame_done_r) begin
                if (!rx_data_valid || rx_data_ready) begin
                    rx_data_out   <= shift_r;
                    rx_parity_err <= frame_perr_r;
                    rx_frame_err  <= frame_ferr_r;
                    rx_data_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: default-rate receiver plus a fast even-parity instance.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_NS   = 8680;
    localparam int P_BIT_NS = 100;

    logic       clock = 1'b0;
    logic       rst;
    logic       line_s;
    logic       ready_s;
    logic [7:0] data_s;
    logic       valid_s, perr_s, ferr_s, ovr_s, busy_s;

    logic       line_p_s;
    logic       ready_p_s;
    logic [7:0] data_p_s;
    logic       valid_p_s, perr_p_s, ferr_p_s, ovr_p_s, busy_p_s;

    int errors = 0;
    int checks = 0;
    int rises = 0;
    int overruns = 0;
    logic valid_q = 1'b0;

    always #5 clock = ~clock;

    uart_rx dut (
        .clock(clock), .rst(rst), .rx_data_in(line_s),
        .rx_data_out(data_s), .rx_data_valid(valid_s), .rx_data_ready(ready_s),
        .rx_parity_err(perr_s), .rx_frame_err(ferr_s),
        .rx_overrun(ovr_s), .rx_busy(busy_s)
    );

    uart_rx #(
        .CLK_RATE(1000000), .BAUD_RATE(100000), .WORD_WIDTH(8),
        .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_p (
        .clock(clock), .rst(rst), .rx_data_in(line_p_s),
        .rx_data_out(data_p_s), .rx_data_valid(valid_p_s), .rx_data_ready(ready_p_s),
        .rx_parity_err(perr_p_s), .rx_frame_err(ferr_p_s),
        .rx_overrun(ovr_p_s), .rx_busy(busy_p_s)
    );

    // Count delivered words (valid rising edges) and overrun pulses.
    always @(negedge clock) begin
        valid_q <= valid_s;
        if (valid_s && !valid_q) rises <= rises + 1;
        if (ovr_s) overruns <= overruns + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_main(input logic [7:0] d, input logic stop_bit);
        line_s = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 8; i++) begin
            line_s = d[i];
            #BIT_NS;
        end
        line_s = stop_bit;
        #BIT_NS;
    endtask

    task automatic send_par(input logic [7:0] d, input logic par_bit);
        line_p_s = 1'b0;
        #P_BIT_NS;
        for (int i = 0; i < 8; i++) begin
            line_p_s = d[i];
            #P_BIT_NS;
        end
        line_p_s = par_bit;
        #P_BIT_NS;
        line_p_s = 1'b1;
        #P_BIT_NS;
        #P_BIT_NS;
    endtask

    initial begin
        logic [7:0] abort_word;
        rst       = 1'b1;
        line_s    = 1'b1;
        line_p_s  = 1'b1;
        ready_s   = 1'b1;
        ready_p_s = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("rst_data",  {24'd0, data_s}, 32'h0);
        check("rst_valid", {31'd0, valid_s}, 32'h0);
        check("rst_perr",  {31'd0, perr_s}, 32'h0);
        check("rst_ferr",  {31'd0, ferr_s}, 32'h0);
        check("rst_ovr",   {31'd0, ovr_s}, 32'h0);
        check("rst_busy",  {31'd0, busy_s}, 32'h0);
        check("rst_p_data", {24'd0, data_p_s}, 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clock);

        // Basic frame with ready held high: one-cycle valid pulse.
        send_main(8'h5A, 1'b1);
        check("b1_rises", rises, 32'd1);
        check("b1_data",  {24'd0, data_s}, 32'h5A);
        check("b1_perr",  {31'd0, perr_s}, 32'h0);
        check("b1_ferr",  {31'd0, ferr_s}, 32'h0);
        check("b1_valid", {31'd0, valid_s}, 32'h0);
        check("b1_busy",  {31'd0, busy_s}, 32'h0);

        // Short low glitch is rejected at the start-bit midpoint.
        line_s = 1'b0;
        #1000;
        check("gl_busy_mid", {31'd0, busy_s}, 32'h1);
        #1000;
        line_s = 1'b1;
        #BIT_NS;
        check("gl_busy",  {31'd0, busy_s}, 32'h0);
        check("gl_rises", rises, 32'd1);
        check("gl_data",  {24'd0, data_s}, 32'h5A);

        // Low stop bit followed by a held-low line: exactly one word, framing error.
        send_main(8'hC3, 1'b0);
        check("br_rises", rises, 32'd2);
        check("br_data",  {24'd0, data_s}, 32'hC3);
        check("br_ferr",  {31'd0, ferr_s}, 32'h1);
        check("br_busy",  {31'd0, busy_s}, 32'h1);
        #(3 * BIT_NS);
        check("br_rises_hold", rises, 32'd2);
        check("br_busy_hold",  {31'd0, busy_s}, 32'h1);
        line_s = 1'b1;
        #BIT_NS;
        check("br_busy_rel",  {31'd0, busy_s}, 32'h0);
        check("br_rises_rel", rises, 32'd2);
        check("br_ferr_held", {31'd0, ferr_s}, 32'h1);

        // Consumer stalled: second back-to-back frame is an overrun.
        ready_s = 1'b0;
        send_main(8'h5A, 1'b1);
        send_main(8'h78, 1'b1);
        check("ov_data",     {24'd0, data_s}, 32'h5A);
        check("ov_valid",    {31'd0, valid_s}, 32'h1);
        check("ov_ferr",     {31'd0, ferr_s}, 32'h0);
        check("ov_overruns", overruns, 32'd1);
        check("ov_rises",    rises, 32'd3);
        ready_s = 1'b1;
        @(posedge clock);
        #1;
        check("ov_valid_drop", {31'd0, valid_s}, 32'h0);
        check("ov_data_hold",  {24'd0, data_s}, 32'h5A);
        @(negedge clock);

        // Reset in the middle of the data bits aborts the frame.
        abort_word = 8'h90;
        line_s = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 4; i++) begin
            line_s = abort_word[i];
            #BIT_NS;
        end
        check("ab_busy_pre", {31'd0, busy_s}, 32'h1);
        rst = 1'b1;
        line_s = 1'b1;
        repeat (3) @(negedge clock);
        check("ab_busy",  {31'd0, busy_s}, 32'h0);
        check("ab_valid", {31'd0, valid_s}, 32'h0);
        check("ab_data",  {24'd0, data_s}, 32'h0);
        rst = 1'b0;
        #BIT_NS;
        check("ab_rises", rises, 32'd3);
        send_main(8'h78, 1'b1);
        check("ab_rx_data",  {24'd0, data_s}, 32'h78);
        check("ab_rx_rises", rises, 32'd4);
        check("ab_rx_ferr",  {31'd0, ferr_s}, 32'h0);
        check("ab_rx_perr",  {31'd0, perr_s}, 32'h0);

        // Even parity: 8'h78 has four ones.
        send_par(8'h78, 1'b0);
        check("p0_data", {24'd0, data_p_s}, 32'h78);
        check("p0_perr", {31'd0, perr_p_s}, 32'h0);
        send_par(8'h78, 1'b1);
        check("p1_data", {24'd0, data_p_s}, 32'h78);
        check("p1_perr", {31'd0, perr_p_s}, 32'h1);
        check("p1_ferr", {31'd0, ferr_p_s}, 32'h0);
        send_par(8'h79, 1'b1);
        check("p2_data", {24'd0, data_p_s}, 32'h79);
        check("p2_perr", {31'd0, perr_p_s}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial-to-parallel UART receiver, the downstream counterpart of uart_tx; consumes the serial line driven by tx_data_out.
- Frame format: 1 start bit (low), WORD_WIDTH data bits LSB first, optional parity bit, 1 stop bit (high).
- Mid-bit sampling, timed from a cycle counter; no oversampling.
- Received word held in an output register with a valid/ready handshake; parity, framing and overrun errors are flagged.

Parameters:
- CLK_RATE, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s. CLKS_PER_BIT = CLK_RATE/BAUD_RATE (integer division; 868 at defaults). HALF_BIT = CLKS_PER_BIT/2 (434).
- WORD_WIDTH, 8, data bits per frame.
- PARITY_EN, 0, 1 = parity bit present between data and stop.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data_in  in  1  asynchronous serial line; idles high.
- rx_data_out  out  WORD_WIDTH  last received word.
- rx_data_valid  out  1  rx_data_out holds an unconsumed word.
- rx_data_ready  in  1  consumer accepts the word when high together with rx_data_valid.
- rx_parity_err  out  1  parity mismatch for the word currently in rx_data_out.
- rx_frame_err  out  1  stop bit sampled low for the word currently in rx_data_out.
- rx_overrun  out  1  one-cycle pulse: a frame completed while the held word was unconsumed.
- rx_busy  out  1  high in any state except IDLE.

Behaviour:
- Synchronizer: rx_data_in passes through 2 flops; both reset to 1. All FSM decisions use the synchronized bit (sync), so there are 2 cycles of input latency.
- Reset values: rx_data_out=0, rx_data_valid=0, rx_parity_err=0, rx_frame_err=0, rx_overrun=0, rx_busy=0; FSM=IDLE; counters=0.
- Reset mid-frame aborts the frame immediately. Nothing is delivered.
- IDLE: when sync==0, go to START and clear the cycle counter.
- START: when the counter reaches HALF_BIT-1, sample sync.
  - sync==1: glitch; return to IDLE.
  - sync==0: go to DATA; clear the counter and the bit index.
- DATA: every CLKS_PER_BIT cycles, sample sync into the shift register (LSB first) and increment the bit index.
  - After WORD_WIDTH bits, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: after CLKS_PER_BIT cycles, sample the parity bit.
  - Even mode: error if the XOR of data and parity bits is 1.
  - Odd mode: error if that XOR is 0.
- STOP: after CLKS_PER_BIT cycles, sample the stop bit, then complete the frame.
  - Stop bit 1: go to IDLE.
  - Stop bit 0: set the frame error and go to BREAK_WAIT.
- BREAK_WAIT: stay until sync==1, then go to IDLE. A held-low line therefore produces exactly one frame.
- Frame completion, on the cycle after the stop sample:
  - If rx_data_valid==0, or a handshake occurs that same cycle: load rx_data_out, rx_parity_err and rx_frame_err from the new frame; rx_data_valid=1.
  - Otherwise (valid high, no handshake): discard the new frame, keep the old word and flags, and pulse rx_overrun for 1 cycle.
- Handshake: on a cycle with rx_data_valid && rx_data_ready and no completion, rx_data_valid goes to 0 on the next cycle. rx_data_out and the error flags hold their values.
- rx_parity_err is always 0 when PARITY_EN=0.
- Frames with errors are still delivered; the flags accompany the data.
- Back-to-back frames: returning to IDLE at mid-stop bit leaves half a bit period to detect the next start edge.
- The counter must be wide enough for CLKS_PER_BIT-1 (clog2). The bit index must be wide enough for WORD_WIDTH.

Test Plan:
- Defaults; reset; drive byte 8'h5A (start, bits 0,1,0,1,1,0,1,0, stop) at 8680 ns/bit with rx_data_ready=1 → rx_data_valid pulses once, rx_data_out=8'h5A, both error flags 0, rx_busy low after the stop sample.
- Glitch: line low for 2000 ns (< HALF_BIT cycles), then high → FSM returns to IDLE, no rx_data_valid, rx_data_out unchanged.
- PARITY_EN=1, PARITY_ODD=0: send 8'h78 with parity 0 → no error. Resend 8'h78 with parity 1 → rx_parity_err=1, rx_data_out=8'h78.
- Stop bit low, then line held low for 3 bit periods before release → one word with rx_frame_err=1; no second frame until the line goes high and a new start bit arrives.
- rx_data_ready=0: send 8'h5A then 8'h78 back-to-back → rx_data_out stays 8'h5A, rx_overrun pulses once at the end of the second frame; raising ready then drops valid on the next cycle.
- Assert rst mid-DATA on a frame of 8'h90, release, then send 8'h78 → no valid for the aborted frame; 8'h78 is received correctly.
